dr_fifo: RTL

DR_FIFO -- requirements
Module: dr_fifo

---
 rtl/dr_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/dr_fifo.sv
// rtl/dr_fifo.sv - bus-side data FIFO with tri-state pop port, head tap and sticky error flags
module dr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WR,
    input  logic [WIDTH-1:0] BIN,
    input  logic             LDBUS,
    input  logic             CLR,
    output logic [WIDTH-1:0] BOUT,
    output logic [WIDTH-1:0] DM,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is still legal when a pop frees the head slot in the same cycle.
    assign do_pop  = LDBUS && !empty;
    assign do_push = WR && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Head is read straight from the array, so BIN never reaches an output combinationally.
    assign DM   = mem[rp];
    assign BOUT = do_pop ? mem[rp] : {WIDTH{1'bz}};

    // Storage array: cleared on reset, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!CLR && do_push) begin
            mem[wp] <= BIN;
        end
    end

    // Pointers, occupancy and sticky error flags; CLR flushes contents but leaves the flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (CLR) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (WR && !do_push) begin
                ovf <= 1'b1;
            end
            if (LDBUS && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule
